operand_fetch_unit: RTL and testbench

//  ID-stage read side of the 5-stage pipeline register file. Reads rs1/rs2 from the regfile
//  and tracks in-flight destinations in an internal EX/MEM/WB shadow pipeline. Forwards or

---
 rtl/operand_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_operand_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: ID-stage operand read, hazard interlock and ID/EX pipeline latch.
// Define OPFETCH_FWD_EN for EX/MEM/WB bypassing; the default build is a stall-only interlock.
module operand_fetch_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             id_valid,
   input  logic             flush,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic [4:0]       rd,
   input  logic             rd_wr,
   input  logic             rd_load,
   input  logic [XLEN-1:0]  rf_rdata1,
   input  logic [XLEN-1:0]  rf_rdata2,
   input  logic [XLEN-1:0]  ex_result,
   input  logic [XLEN-1:0]  mem_result,
   input  logic [XLEN-1:0]  wb_data,
   output logic             id_stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_op1,
   output logic [XLEN-1:0]  ex_op2,
   output logic [4:0]       ex_rd,
   output logic             ex_regwr,
   output logic [CNT_W-1:0] stall_cnt
);

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic       v;
      logic       wr;
      logic [4:0] rd;
      logic       load;
   } slot_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   slot_t            s_ex_q, s_ex_d;
   slot_t            s_mem_q;
   slot_t            s_wb_q;
   state_e           state_q, state_d;
   logic [XLEN-1:0]  op1_q, op1_d;
   logic [XLEN-1:0]  op2_q, op2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ex_m1, mem_m1, wb_m1;
   logic ex_m2, mem_m2, wb_m2;
   logic hazard;
   logic issue;

   // A slot only hazards a real, written, non-x0 destination.
   function automatic logic slot_match(input slot_t s, input logic [4:0] src);
      return s.v && s.wr && (s.rd == src) && (src != 5'd0);
   endfunction

   assign ex_m1  = use_rs1 && slot_match(s_ex_q,  rs1);
   assign mem_m1 = use_rs1 && slot_match(s_mem_q, rs1);
   assign wb_m1  = use_rs1 && slot_match(s_wb_q,  rs1);
   assign ex_m2  = use_rs2 && slot_match(s_ex_q,  rs2);
   assign mem_m2 = use_rs2 && slot_match(s_mem_q, rs2);
   assign wb_m2  = use_rs2 && slot_match(s_wb_q,  rs2);

`ifdef OPFETCH_FWD_EN
   // Only a load in EX cannot be bypassed; one bubble moves it to MEM.
   assign hazard = s_ex_q.load && (ex_m1 || ex_m2);
`else
   // WB writes land on the same edge as the ID/EX latch, so WB must be waited out too.
   assign hazard = ex_m1 || mem_m1 || wb_m1 || ex_m2 || mem_m2 || wb_m2;
`endif

   assign id_stall = id_valid && !flush && hazard;
   assign issue    = id_valid && !flush && !hazard;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      op1_d = op1_q;
      op2_d = op2_q;
      if (issue) begin
         op1_d = rf_rdata1;
         op2_d = rf_rdata2;
`ifdef OPFETCH_FWD_EN
         // Youngest producer wins.
         if (ex_m1)       op1_d = ex_result;
         else if (mem_m1) op1_d = mem_result;
         else if (wb_m1)  op1_d = wb_data;
         if (ex_m2)       op2_d = ex_result;
         else if (mem_m2) op2_d = mem_result;
         else if (wb_m2)  op2_d = wb_data;
`endif
         if (use_rs1 && (rs1 == 5'd0)) op1_d = '0;
         if (use_rs2 && (rs2 == 5'd0)) op2_d = '0;
      end
   end

   always_comb begin
      s_ex_d = '0;
      if (issue) begin
         s_ex_d.v    = 1'b1;
         s_ex_d.wr   = rd_wr;
         s_ex_d.rd   = rd;
         s_ex_d.load = rd_load;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:   if (id_stall)  state_d = STALL;
         STALL: if (!id_stall) state_d = RUN;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (id_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: all state here is pipeline control, so all of it is reset; there is no storage array to exempt.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         s_ex_q  <= '0;
         s_mem_q <= '0;
         s_wb_q  <= '0;
         state_q <= RUN;
         op1_q   <= '0;
         op2_q   <= '0;
         cnt_q   <= '0;
      end else begin
         s_ex_q  <= s_ex_d;
         s_mem_q <= s_ex_q;
         s_wb_q  <= s_mem_q;
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid  = s_ex_q.v;
   assign ex_regwr  = s_ex_q.wr;
   assign ex_rd     = s_ex_q.rd;
   assign ex_op1    = op1_q;
   assign ex_op2    = op2_q;
   assign stall_cnt = cnt_q;

   // Inputs and slot fields the selected configuration has no use for.
   logic unused_bits;
`ifdef OPFETCH_FWD_EN
   assign unused_bits = s_mem_q.load ^ s_wb_q.load;
`else
   assign unused_bits = ^{ex_result, mem_result, wb_data, s_ex_q.load, s_mem_q.load, s_wb_q.load};
`endif

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: scoreboard bench for operand_fetch_unit; expected ID/EX contents are
// queued when an instruction is presented and compared one cycle later.
module tb_operand_fetch_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 16;

   logic             CLK;
   logic             Reset;
   logic             id_valid, flush;
   logic [4:0]       rs1, rs2, rd;
   logic             use_rs1, use_rs2, rd_wr, rd_load;
   logic [XLEN-1:0]  rf_rdata1, rf_rdata2, ex_result, mem_result, wb_data;
   logic             id_stall, ex_valid, ex_regwr;
   logic [XLEN-1:0]  ex_op1, ex_op2;
   logic [4:0]       ex_rd;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      logic            valid;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [4:0]      rd;
      logic            regwr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   operand_fetch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .flush(flush),
      .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
      .rd(rd), .rd_wr(rd_wr), .rd_load(rd_load),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_result(ex_result), .mem_result(mem_result), .wb_data(wb_data),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_rd(ex_rd), .ex_regwr(ex_regwr), .stall_cnt(stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, got running, want finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a cycle, check id_stall, queue the expected ID/EX latch
   // contents, then compare them just after the edge.
   task automatic drive(input logic v, input logic fl,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] d, input logic wr, input logic ld,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic exp_stall,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
      exp_t e;
      logic iss;
      id_valid = v;  flush = fl;
      rs1 = r1;  use_rs1 = u1;
      rs2 = r2;  use_rs2 = u2;
      rd = d;  rd_wr = wr;  rd_load = ld;
      rf_rdata1 = d1;  rf_rdata2 = d2;
      #1;
      check("id_stall", {31'd0, id_stall}, {31'd0, exp_stall});
      iss = v && !fl && !exp_stall;
      e.valid = iss;
      e.op1   = e1;
      e.op2   = e2;
      e.rd    = d;
      e.regwr = iss && wr;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
         check("ex_regwr", {31'd0, ex_regwr}, {31'd0, e.regwr});
         if (e.valid) begin
            check("ex_op1", ex_op1, e.op1);
            check("ex_op2", ex_op2, e.op2);
            check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
         end
      end
   endtask

   // Reader of x20 sits in a stall; Reset is raised mid-cycle and must clear everything at once.
   task automatic reset_mid_stall(input logic [CNT_W-1:0] cnt_before);
      id_valid = 1'b1;  flush = 1'b0;
      rs1 = 5'd20;  use_rs1 = 1'b1;
      rs2 = 5'd2;   use_rs2 = 1'b1;
      rd = 5'd21;  rd_wr = 1'b1;  rd_load = 1'b0;
      rf_rdata1 = 32'h0;  rf_rdata2 = 32'h2;
      #1;
      check("rst_pre_stall", {31'd0, id_stall}, 32'd1);
      check("rst_pre_cnt", {16'd0, stall_cnt}, {16'd0, cnt_before});
      #1;
      Reset = 1'b1;
      #1;
      check("rst_id_stall", {31'd0, id_stall}, 32'd0);
      check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_ex_regwr", {31'd0, ex_regwr}, 32'd0);
      check("rst_ex_op1", ex_op1, 32'd0);
      check("rst_ex_op2", ex_op2, 32'd0);
      check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
      check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      #1;
      Reset = 1'b0;
      id_valid = 1'b0;
      exp_q.delete();
      @(posedge CLK);
      #1;
      check("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
   endtask

   initial begin
      Reset = 1'b1;
      id_valid = 1'b0;  flush = 1'b0;
      rs1 = '0;  rs2 = '0;  rd = '0;
      use_rs1 = 1'b0;  use_rs2 = 1'b0;  rd_wr = 1'b0;  rd_load = 1'b0;
      rf_rdata1 = '0;  rf_rdata2 = '0;
      ex_result = 32'hE0;  mem_result = 32'hE1;  wb_data = 32'hE2;
      #12;
      check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("reset_ex_regwr", {31'd0, ex_regwr}, 32'd0);
      check("reset_ex_op1", ex_op1, 32'd0);
      check("reset_ex_op2", ex_op2, 32'd0);
      check("reset_ex_rd", {27'd0, ex_rd}, 32'd0);
      check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("reset_id_stall", {31'd0, id_stall}, 32'd0);
      Reset = 1'b0;
      @(posedge CLK);
      #1;

`ifdef OPFETCH_FWD_EN
      // EX bypass: add x5 then read x5.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd5,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      ex_result = 32'h11;
      drive(1,0, 5'd5,1, 5'd2,1, 5'd0,0,0, 32'h0,32'h2, 0, 32'h11,32'h2);
      ex_result = 32'hE0;

      // Load-use: exactly one bubble, then the load data from MEM.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd6,1,1, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd6,1, 5'd22,1,0, 32'h1,32'h0, 1, 32'h0,32'h0);
      check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      mem_result = 32'hDEAD;
      drive(1,0, 5'd1,1, 5'd6,1, 5'd22,1,0, 32'h1,32'h0, 0, 32'h1,32'hDEAD);
      check("lu_stall_cnt_hold", {16'd0, stall_cnt}, 32'd1);
      mem_result = 32'hE1;

      // Same-cycle WB: regfile still stale, value must come from wb_data.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd7,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd23,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd24,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      wb_data = 32'h42;
      drive(1,0, 5'd7,1, 5'd2,1, 5'd0,0,0, 32'h0,32'h2, 0, 32'h42,32'h2);
      wb_data = 32'hE2;

      // Two writers of x9 in EX and MEM: the younger (EX) wins.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd9,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd9,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      ex_result = 32'hA;  mem_result = 32'hB;  wb_data = 32'hC;
      drive(1,0, 5'd9,1, 5'd9,1, 5'd0,0,0, 32'h0,32'h0, 0, 32'hA,32'hA);
      ex_result = 32'hE0;  mem_result = 32'hE1;  wb_data = 32'hE2;

      // x0 is never forwarded and reads as zero.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd0,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      ex_result = 32'h99;
      drive(1,0, 5'd0,1, 5'd2,1, 5'd25,1,0, 32'h55,32'h2, 0, 32'h0,32'h2);
      ex_result = 32'hE0;

      // Flush during load-use stall, then a later reader picks the load up from WB.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd6,1,1, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd6,1, 5'd2,1, 5'd22,1,0, 32'h0,32'h2, 1, 32'h0,32'h0);
      drive(1,1, 5'd6,1, 5'd2,1, 5'd22,1,0, 32'h0,32'h2, 0, 32'h0,32'h0);
      check("flush_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      wb_data = 32'h66;
      drive(1,0, 5'd1,1, 5'd6,1, 5'd23,1,0, 32'h1,32'h0, 0, 32'h1,32'h66);
      wb_data = 32'hE2;

      // Reset while the reader of a load sits in its stall.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd20,1,1, 32'h5A,32'h5B, 0, 32'h5A,32'h5B);
      reset_mid_stall(16'd2);
`else
      // Distance 1: three bubbles, then the now-current regfile value.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd8,1,0, 32'h10,32'h20, 0, 32'h10,32'h20);
      repeat (3) drive(1,0, 5'd8,1, 5'd3,1, 5'd9,1,0, 32'h0,32'h30, 1, 32'h0,32'h0);
      drive(1,0, 5'd8,1, 5'd3,1, 5'd9,1,0, 32'h88,32'h30, 0, 32'h88,32'h30);
      check("d1_stall_cnt", {16'd0, stall_cnt}, 32'd3);

      // Distance 2: two bubbles.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd10,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd11,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      repeat (2) drive(1,0, 5'd10,1, 5'd2,1, 5'd25,1,0, 32'h0,32'h2, 1, 32'h0,32'h0);
      drive(1,0, 5'd10,1, 5'd2,1, 5'd25,1,0, 32'hA0,32'h2, 0, 32'hA0,32'h2);
      check("d2_stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // Distance 3 on rs2: one bubble.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd12,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd13,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd2,1, 5'd14,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd1,1, 5'd12,1, 5'd26,1,0, 32'h1,32'h0, 1, 32'h0,32'h0);
      drive(1,0, 5'd1,1, 5'd12,1, 5'd26,1,0, 32'h1,32'hC0, 0, 32'h1,32'hC0);
      check("d3_stall_cnt", {16'd0, stall_cnt}, 32'd6);

      // x0 destination never hazards.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd0,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd0,1, 5'd2,1, 5'd27,1,0, 32'h0,32'h66, 0, 32'h0,32'h66);

      // Unused source never hazards and passes the regfile value.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd15,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd15,0, 5'd2,1, 5'd28,1,0, 32'h77,32'h2, 0, 32'h77,32'h2);

      // Producer that does not write rd never hazards.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd16,0,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd16,1, 5'd2,1, 5'd29,1,0, 32'h3,32'h2, 0, 32'h3,32'h2);

      // id_valid low: no stall, bubble.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd17,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(0,0, 5'd17,1, 5'd2,1, 5'd30,1,0, 32'h0,32'h2, 0, 32'h0,32'h0);

      // Flush in the middle of a stall drops the stall and issues a bubble.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd18,1,0, 32'h1,32'h2, 0, 32'h1,32'h2);
      drive(1,0, 5'd18,1, 5'd2,1, 5'd31,1,0, 32'h0,32'h2, 1, 32'h0,32'h0);
      check("pre_flush_cnt", {16'd0, stall_cnt}, 32'd7);
      drive(1,1, 5'd18,1, 5'd2,1, 5'd31,1,0, 32'h0,32'h2, 0, 32'h0,32'h0);
      check("flush_stall_cnt", {16'd0, stall_cnt}, 32'd7);

      // Reset asserted in the second stall cycle.
      drive(1,0, 5'd1,1, 5'd2,1, 5'd20,1,0, 32'h5A,32'h5B, 0, 32'h5A,32'h5B);
      drive(1,0, 5'd20,1, 5'd2,1, 5'd21,1,0, 32'h0,32'h2, 1, 32'h0,32'h0);
      reset_mid_stall(16'd8);
`endif

      // After reset the dropped reader issues cleanly with no leftover hazard.
      drive(1,0, 5'd20,1, 5'd2,1, 5'd21,1,0, 32'h7,32'h8, 0, 32'h7,32'h8);
      drive(0,0, 5'd1,1, 5'd2,1, 5'd0,0,0, 32'h0,32'h0, 0, 32'h0,32'h0);
      check("final_stall_cnt", {16'd0, stall_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
